tlc_multiway_ctrl: RTL

- Parametrised N-way traffic-light controller; successor to the fixed six-state intersection controller.
- Serves NUM_DIR approaches in round-robin order, one approach green at a time.
- Green, yellow and all-red clearance durations are runtime-programmable.
- Demand-actuated skipping of idle approaches; emergency pre-emption to a selected approach.
- Sits between the intersection sensor/config logic and the lamp drivers.

---
 rtl/tlc_pkg.sv | 15 +
 rtl/tlc_rr_pick.sv | 30 +++
 rtl/tlc_multiway_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared types and lamp encodings for the multi-way traffic-light controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_ALLRED    = 2'd0,
    ST_GREEN     = 2'd1,
    ST_YELLOW    = 2'd2,
    ST_EMG_GREEN = 2'd3
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/tlc_rr_pick.sv
// Combinational round-robin finder: first set demand bit at or after start, wrapping.
module tlc_rr_pick #(
  parameter int unsigned NUM_DIR = 4,
  parameter int unsigned DIR_W   = $clog2(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] demand,
  input  logic [DIR_W-1:0]   start,
  output logic               found,
  output logic [DIR_W-1:0]   idx
);

  localparam int unsigned JW = DIR_W + 1;

  logic [JW-1:0] j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int unsigned k = 0; k < NUM_DIR; k++) begin
      j = {1'b0, start} + JW'(k);
      if (j >= JW'(NUM_DIR)) j = j - JW'(NUM_DIR);
      if (!found && demand[j[DIR_W-1:0]]) begin
        found = 1'b1;
        idx   = j[DIR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tlc_multiway_ctrl.sv
// N-way round-robin traffic-light controller with programmable dwells,
// demand-actuated skipping and emergency pre-emption.
module tlc_multiway_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned NUM_DIR = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DIR_W   = $clog2(NUM_DIR)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CNT_W-1:0]     green_time,
  input  logic [CNT_W-1:0]     yellow_time,
  input  logic [CNT_W-1:0]     allred_time,
  input  logic [NUM_DIR-1:0]   demand,
  input  logic                 emg_req,
  input  logic [DIR_W-1:0]     emg_dir,
  output logic [3*NUM_DIR-1:0] lights,
  output logic [DIR_W-1:0]     cur_dir,
  output logic [1:0]           phase
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     dwell_q, dwell_d;
  logic [CNT_W-1:0]     dwell_eff;
  logic [DIR_W-1:0]     cur_q, cur_d;
  logic [DIR_W-1:0]     next_q, next_d;
  logic [3*NUM_DIR-1:0] lights_q, lights_d;
  logic                 done;
  logic                 go;
  logic [NUM_DIR-1:0]   dem_masked;
  logic [DIR_W-1:0]     pick_start;
  logic                 pick_found;
  logic [DIR_W-1:0]     pick_idx;

  function automatic logic [CNT_W-1:0] dur(input logic [CNT_W-1:0] v);
    return (v == '0) ? CNT_W'(1) : v;
  endfunction

  // The current approach never competes in its own arbitration.
  assign dem_masked = demand & ~(NUM_DIR'(1) << cur_q);
  assign pick_start = (cur_q == DIR_W'(NUM_DIR - 1)) ? '0 : cur_q + DIR_W'(1);

  tlc_rr_pick #(
    .NUM_DIR (NUM_DIR),
    .DIR_W   (DIR_W)
  ) u_pick (
    .demand (dem_masked),
    .start  (pick_start),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // dwell_q == 0 only straight after reset, before the first all-red dwell is latched.
  assign dwell_eff = (dwell_q == '0) ? dur(allred_time) : dwell_q;
  assign done      = (cnt_q == dwell_eff - CNT_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dwell_d  = dwell_q;
    cur_d    = cur_q;
    next_d   = next_q;
    go       = 1'b0;
    lights_d = {NUM_DIR{LAMP_RED}};
    if (en) begin
      dwell_d = dwell_eff;
      unique case (state_q)
        ST_ALLRED: begin
          if (emg_req) next_d = emg_dir;
          if (done) begin
            go = 1'b1;
            if (emg_req) begin
              state_d = ST_EMG_GREEN;
              cur_d   = emg_dir;
            end else begin
              state_d = ST_GREEN;
              cur_d   = next_q;
            end
          end
        end
        ST_GREEN: begin
          if (emg_req) begin
            go = 1'b1;
            if (emg_dir == cur_q) begin
              state_d = ST_EMG_GREEN;
            end else begin
              state_d = ST_YELLOW;
              next_d  = emg_dir;
            end
          end else if (done && pick_found) begin
            go      = 1'b1;
            state_d = ST_YELLOW;
            next_d  = pick_idx;
          end
        end
        ST_YELLOW: begin
          if (emg_req) next_d = emg_dir;
          if (done) begin
            go      = 1'b1;
            state_d = ST_ALLRED;
          end
        end
        ST_EMG_GREEN: begin
          if (!emg_req) begin
            go      = 1'b1;
            state_d = ST_GREEN;
          end else if (emg_dir != cur_q) begin
            go      = 1'b1;
            state_d = ST_YELLOW;
            next_d  = emg_dir;
          end
        end
        default: ;
      endcase
      // Fresh dwell on every state entry; otherwise count up and saturate at D-1.
      if (go) begin
        cnt_d = '0;
        unique case (state_d)
          ST_ALLRED: dwell_d = dur(allred_time);
          ST_YELLOW: dwell_d = dur(yellow_time);
          default:   dwell_d = dur(green_time);
        endcase
      end else if (!done) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    for (int i = 0; i < NUM_DIR; i++) begin
      if (DIR_W'(i) == cur_d) begin
        unique case (state_d)
          ST_GREEN, ST_EMG_GREEN: lights_d[3*i +: 3] = LAMP_GRN;
          ST_YELLOW:              lights_d[3*i +: 3] = LAMP_YEL;
          default:                lights_d[3*i +: 3] = LAMP_RED;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ALLRED;
      cnt_q    <= '0;
      dwell_q  <= '0;
      cur_q    <= '0;
      next_q   <= '0;
      lights_q <= {NUM_DIR{LAMP_RED}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dwell_q  <= dwell_d;
      cur_q    <= cur_d;
      next_q   <= next_d;
      lights_q <= lights_d;
    end
  end

  assign lights  = lights_q;
  assign cur_dir = cur_q;
  assign phase   = state_q;

endmodule
